// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response encodings, read-engine state
// encoding and default bus widths.
package axi4l_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REG_RD    = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_RESP      = 2'd3
  } rd_state_e;

endpackage

// File: rtl/s_axi4l_read_channel.sv
// AXI4-Lite slave read engine: one outstanding read, word-addressed strobe to
// the register file, captured data returned on R with an OKAY response.
module s_axi4l_read_channel
  import axi4l_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = AXI_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     i_axi_araddr,
  input  logic [3:0]                i_axi_arcache,
  input  logic [2:0]                i_axi_arprot,
  input  logic                      i_axi_araddr_valid,
  output logic                      o_axi_araddr_ready,
  output logic [DATA_WIDTH-1:0]     o_axi_rdata,
  output logic [1:0]                o_axi_rresp,
  output logic                      o_axi_rdata_valid,
  input  logic                      i_axi_rdata_ready,
  output logic [REG_ADDR_WIDTH-1:0] o_raddr,
  output logic                      o_raddr_valid,
  input  logic [DATA_WIDTH-1:0]     i_rdata
);

  rd_state_e                 state_r;
  rd_state_e                 state_next_s;
  logic                      ar_hs_s;
  logic                      arready_next_s;
  logic                      raddr_valid_next_s;
  logic                      rvalid_next_s;
  logic [REG_ADDR_WIDTH-1:0] raddr_next_s;
  logic [DATA_WIDTH-1:0]     rdata_next_s;
  logic                      unused_s;

  // Cache/protection attributes and the byte-lane/upper address bits carry no meaning here.
  assign unused_s = ^{i_axi_arcache, i_axi_arprot, i_axi_araddr};

  assign ar_hs_s = (state_r == ST_IDLE) && i_axi_araddr_valid && o_axi_araddr_ready;

  // State register.
  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ar_hs_s) begin
          state_next_s = ST_REG_RD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REG_RD:    state_next_s = ST_WAIT_DATA;
      ST_WAIT_DATA: state_next_s = ST_RESP;
      ST_RESP: begin
        if (i_axi_rdata_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: every output is derived from the state being entered so it can be registered.
  always_comb begin
    arready_next_s     = 1'b0;
    raddr_valid_next_s = 1'b0;
    rvalid_next_s      = 1'b0;
    case (state_next_s)
      ST_IDLE:      arready_next_s     = 1'b1;
      ST_REG_RD:    raddr_valid_next_s = 1'b1;
      ST_WAIT_DATA: rvalid_next_s      = 1'b0;
      ST_RESP:      rvalid_next_s      = 1'b1;
      default:      arready_next_s     = 1'b0;
    endcase

    if (ar_hs_s) begin
      raddr_next_s = i_axi_araddr[REG_ADDR_WIDTH+1:2];
    end else begin
      raddr_next_s = o_raddr;
    end

    // Register file answers one cycle after the strobe; hold the word until the next read.
    if (state_r == ST_WAIT_DATA) begin
      rdata_next_s = i_rdata;
    end else begin
      rdata_next_s = o_axi_rdata;
    end
  end

  // Output registers.
  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      o_axi_araddr_ready <= 1'b0;
      o_raddr_valid      <= 1'b0;
      o_axi_rdata_valid  <= 1'b0;
      o_raddr            <= {REG_ADDR_WIDTH{1'b0}};
      o_axi_rdata        <= {DATA_WIDTH{1'b0}};
      o_axi_rresp        <= RESP_OKAY;
    end else begin
      o_axi_araddr_ready <= arready_next_s;
      o_raddr_valid      <= raddr_valid_next_s;
      o_axi_rdata_valid  <= rvalid_next_s;
      o_raddr            <= raddr_next_s;
      o_axi_rdata        <= rdata_next_s;
      o_axi_rresp        <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_s_axi4l_read_channel.sv
// Self-checking bench for s_axi4l_read_channel: table-driven reads, hand-written
// corner sequences and a randomized run against a transaction-level scoreboard.
module tb_s_axi4l_read_channel;
  import axi4l_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  exp_ra;
    logic [31:0] regval;
    int          rdelay;
  } rd_vec_t;

  typedef struct {
    logic [7:0]  ra;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] araddr;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  raddr;
  logic        raddr_valid;
  logic [31:0] rf_data;

  logic [31:0] regfile [256];
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  int          age = 0;
  bit          seen_edge = 1'b0;

  always #5 clk = ~clk;

  s_axi4l_read_channel dut (
    .i_axi_clock        (clk),
    .i_axi_aresetn      (rst_n),
    .i_axi_araddr       (araddr),
    .i_axi_arcache      (arcache),
    .i_axi_arprot       (arprot),
    .i_axi_araddr_valid (arvalid),
    .o_axi_araddr_ready (arready),
    .o_axi_rdata        (rdata),
    .o_axi_rresp        (rresp),
    .o_axi_rdata_valid  (rvalid),
    .i_axi_rdata_ready  (rready),
    .o_raddr            (raddr),
    .o_raddr_valid      (raddr_valid),
    .i_rdata            (rf_data)
  );

  // Register-file model: answers a strobe one cycle later, garbage otherwise.
  always @(posedge clk) rf_data <= raddr_valid ? regfile[raddr] : $urandom;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding read, strobe 1 cycle after accept,
  // R beat from 3 cycles after accept until RREADY, data = regfile[word address].
  task automatic monitor();
    if (!rst_n) begin
      q.delete();
      return;
    end
    if (!seen_edge) return;
    check("one_outstanding", 32'(arready), 32'(q.size() == 0));
    if (q.size() > 0) age++;
    check("strobe_timing", 32'(raddr_valid), 32'(q.size() > 0 && age == 1));
    if (raddr_valid && q.size() > 0) check("strobe_addr", 32'(raddr), 32'(q[0].ra));
    check("rvalid_timing", 32'(rvalid), 32'(q.size() > 0 && age >= 3));
    check("rresp_okay", 32'(rresp), 32'(RESP_OKAY));
    if (rvalid && q.size() > 0) check("beat_data", rdata, q[0].d);
    if (rvalid && rready && q.size() > 0) void'(q.pop_front());
    if (arvalid && arready) begin
      exp_t e;
      e.ra = 8'((araddr / 32'd4) % 32'd256);
      e.d  = regfile[e.ra];
      q.push_back(e);
      age = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    seen_edge = rst_n;
    #1;
  endtask

  task automatic wait_arready(input string name);
    int n = 0;
    while (!arready && n < 16) begin
      step();
      n++;
    end
    check(name, 32'(arready), 32'd1);
  endtask

  task automatic do_read(input rd_vec_t v);
    araddr  = v.addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    wait_arready("ar_accept_bound");
    step();
    araddr = v.addr ^ 32'h0000_0040;
    check("strobe", 32'(raddr_valid), 32'd1);
    check("raddr", 32'(raddr), 32'(v.exp_ra));
    check("arready_busy", 32'(arready), 32'd0);
    step();
    check("strobe_one_cycle", 32'(raddr_valid), 32'd0);
    check("rvalid_early", 32'(rvalid), 32'd0);
    step();
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, v.regval);
    check("rresp", 32'(rresp), 32'd0);
    for (int k = 0; k < v.rdelay; k++) begin
      step();
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, v.regval);
      check("arready_hold", 32'(arready), 32'd0);
    end
    rready  = 1'b1;
    arvalid = 1'b0;
    step();
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
    rready = 1'b0;
  endtask

  initial begin
    rd_vec_t vec[6];
    bit      hs;

    rst_n = 1'b0; araddr = 32'd0; arcache = 4'hF; arprot = 3'h7;
    arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 256; i++) regfile[i] = $urandom;

    vec[0] = '{32'h0000_0008, 8'd2,    32'hDEAD_BEEF, 0};
    vec[1] = '{32'h0000_000B, 8'd2,    32'hCAFE_F00D, 0};
    vec[2] = '{32'h0000_03FC, 8'd255,  32'h1234_5678, 2};
    vec[3] = '{32'h1234_5678, 8'h9E,   32'hA5A5_5A5A, 5};
    vec[4] = '{32'hFFFF_FC03, 8'd0,    32'hFFFF_FFFF, 1};
    vec[5] = '{32'h0000_0404, 8'd1,    32'h0000_0001, 0};

    // Reset state.
    repeat (3) step();
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_raddr_valid", 32'(raddr_valid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    rst_n = 1'b1;
    check("arready_before_edge", 32'(arready), 32'd0);
    step();
    check("arready_after_edge", 32'(arready), 32'd1);

    // Table-driven single reads (aligned, unaligned, high word, ignored upper bits, backpressure).
    for (int i = 0; i < 6; i++) begin
      regfile[vec[i].exp_ra] = vec[i].regval;
      do_read(vec[i]);
    end

    // Back-to-back: ARVALID held, RREADY high, beats spaced 4 cycles.
    regfile[1] = 32'h1111_0001;
    regfile[3] = 32'h3333_0003;
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b1;
    wait_arready("b2b_accept_bound");
    step();
    check("b2b_strobe1", 32'(raddr_valid), 32'd1);
    check("b2b_raddr1", 32'(raddr), 32'd1);
    araddr = 32'hC;
    step();
    step();
    check("b2b_rvalid1", 32'(rvalid), 32'd1);
    check("b2b_rdata1", rdata, 32'h1111_0001);
    step();
    check("b2b_gap_rvalid", 32'(rvalid), 32'd0);
    check("b2b_gap_arready", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
    check("b2b_strobe2", 32'(raddr_valid), 32'd1);
    check("b2b_raddr2", 32'(raddr), 32'd3);
    step();
    step();
    check("b2b_rvalid2", 32'(rvalid), 32'd1);
    check("b2b_rdata2", rdata, 32'h3333_0003);
    step();
    rready = 1'b0;

    // Reset while waiting for register data: the read is dropped.
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
    wait_arready("rstmid_accept_bound");
    step();
    arvalid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rstmid_arready", 32'(arready), 32'd0);
    check("rstmid_raddr_valid", 32'(raddr_valid), 32'd0);
    check("rstmid_rvalid", 32'(rvalid), 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_raddr", 32'(raddr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rstmid_no_beat", 32'(rvalid), 32'd0);
    end
    regfile[vec[0].exp_ra] = vec[0].regval;
    do_read(vec[0]);

    // Randomized traffic checked by the scoreboard in monitor().
    for (int c = 0; c < 1500; c++) begin
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        arvalid = 1'b1;
        araddr  = $urandom;
      end
      rready = 1'($urandom_range(0, 1));
      hs = arvalid && arready;
      step();
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (8) step();
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
